fust_s_issue_sched: RTL and testbench

//  Issue scheduler for the scalar functional-unit status table (ALU, LD/ST, BR).
//  It tracks one in-flight op per FU through its lifecycle:

---
 rtl/datapath_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/fust_s_issue_sched.sv | 105 ++++++++++
 tb/tb_fust_s_issue_sched.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and constants for the scalar FU status table
package datapath_pkg;

  localparam int NUM_FU = 3;
  localparam int TAGW   = 5;
  localparam int FUW    = 2;

  localparam int FU_ALU = 0;
  localparam int FU_LS  = 1;
  localparam int FU_BR  = 2;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_WAIT,
    S_READY,
    S_EXEC,
    S_SQUASH
  } fu_slot_state_t;

  typedef struct packed {
    fu_slot_state_t  state;
    logic [TAGW-1:0] t1;
    logic [TAGW-1:0] t2;
    logic            spec;
  } fu_slot_t;

  localparam fu_slot_t SLOT_EMPTY = '{state: S_EMPTY, t1: '0, t2: '0, spec: 1'b0};

  // A tag matching the live writeback broadcast counts as already available.
  function automatic logic [TAGW-1:0] eff_tag(input logic [TAGW-1:0] t,
                                              input logic            v,
                                              input logic [TAGW-1:0] w);
    return (v && (t == w)) ? '0 : t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting at ptr, wrapping
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fust_s_issue_sched.sv
// rtl/fust_s_issue_sched.sv - per-FU op lifecycle tracking, wakeup and round-robin issue
module fust_s_issue_sched
  import datapath_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              disp_en,
  input  logic [FUW-1:0]    disp_fu,
  input  logic [TAGW-1:0]   disp_t1,
  input  logic [TAGW-1:0]   disp_t2,
  input  logic              disp_spec,
  output logic [NUM_FU-1:0] disp_ready,
  input  logic              wb_valid,
  input  logic [TAGW-1:0]   wb_tag,
  input  logic [NUM_FU-1:0] fu_ready,
  output logic [NUM_FU-1:0] issue_valid,
  input  logic [NUM_FU-1:0] fu_done,
  input  logic              flush,
  input  logic              resolved,
  output logic [NUM_FU-1:0] busy
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  fu_slot_t          slots   [NUM_FU];
  fu_slot_t          slots_n [NUM_FU];
  logic [PW-1:0]     ptr, ptr_n;
  logic [NUM_FU-1:0] cand, gnt;

  // Spec slots being flushed are masked before arbitration so another FU can take the port.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      cand[i]       = (slots[i].state == S_READY) && fu_ready[i] && !(flush && slots[i].spec);
      disp_ready[i] = (slots[i].state == S_EMPTY);
    end
  end

  assign busy        = ~disp_ready;
  assign issue_valid = gnt;

  rr_arbiter #(.N(NUM_FU), .PW(PW)) u_arb (
    .req (cand),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    ptr_n = ptr;
    for (int g = 0; g < NUM_FU; g++)
      if (gnt[g]) ptr_n = PW'((g + 1) % NUM_FU);
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      slots_n[i] = slots[i];
      unique case (slots[i].state)
        S_EMPTY: begin
          if (disp_en && (disp_fu == FUW'(i)) && !(flush && disp_spec)) begin
            slots_n[i].t1    = eff_tag(disp_t1, wb_valid, wb_tag);
            slots_n[i].t2    = eff_tag(disp_t2, wb_valid, wb_tag);
            slots_n[i].spec  = disp_spec;
            slots_n[i].state = (eff_tag(disp_t1, wb_valid, wb_tag) == '0 &&
                                eff_tag(disp_t2, wb_valid, wb_tag) == '0) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush && slots[i].spec) begin
            slots_n[i] = SLOT_EMPTY;
          end else begin
            slots_n[i].t1 = eff_tag(slots[i].t1, wb_valid, wb_tag);
            slots_n[i].t2 = eff_tag(slots[i].t2, wb_valid, wb_tag);
            if (eff_tag(slots[i].t1, wb_valid, wb_tag) == '0 &&
                eff_tag(slots[i].t2, wb_valid, wb_tag) == '0)
              slots_n[i].state = S_READY;
          end
        end
        S_READY: begin
          if (flush && slots[i].spec) slots_n[i] = SLOT_EMPTY;
          else if (gnt[i])            slots_n[i].state = S_EXEC;
        end
        S_EXEC: begin
          if (fu_done[i])                  slots_n[i] = SLOT_EMPTY;
          else if (flush && slots[i].spec) slots_n[i].state = S_SQUASH;
        end
        S_SQUASH: begin
          if (fu_done[i]) slots_n[i] = SLOT_EMPTY;
        end
        default: slots_n[i] = SLOT_EMPTY;
      endcase
      if (resolved && !flush && slots_n[i].state != S_SQUASH)
        slots_n[i].spec = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_FU; i++) slots[i] <= SLOT_EMPTY;
      ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) slots[i] <= slots_n[i];
      ptr <= ptr_n;
    end
  end

endmodule

// File: tb/tb_fust_s_issue_sched.sv
// tb/tb_fust_s_issue_sched.sv - directed self-checking bench for fust_s_issue_sched
module tb_fust_s_issue_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic       disp_en;
  logic [1:0] disp_fu;
  logic [4:0] disp_t1, disp_t2;
  logic       disp_spec;
  logic [2:0] disp_ready;
  logic       wb_valid;
  logic [4:0] wb_tag;
  logic [2:0] fu_ready;
  logic [2:0] issue_valid;
  logic [2:0] fu_done;
  logic       flush, resolved;
  logic [2:0] busy;

  int n_tests = 0;
  int n_fail  = 0;

  fust_s_issue_sched dut (
    .CLK(CLK), .RST(RST),
    .disp_en(disp_en), .disp_fu(disp_fu), .disp_t1(disp_t1), .disp_t2(disp_t2),
    .disp_spec(disp_spec), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .fu_done(fu_done),
    .flush(flush), .resolved(resolved), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_en = 0; disp_fu = 0; disp_t1 = 0; disp_t2 = 0; disp_spec = 0;
    wb_valid = 0; wb_tag = 0; fu_done = 0; flush = 0; resolved = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic disp(input logic [1:0] fu, input logic [4:0] t1, input logic [4:0] t2,
                      input logic sp);
    disp_en = 1; disp_fu = fu; disp_t1 = t1; disp_t2 = t2; disp_spec = sp;
  endtask

  initial begin
    idle();
    RST = 1; fu_ready = 3'b111;
    tick(); tick();
    RST = 0;
    settle();
    chk("rst_busy", busy, 3'b000);
    chk("rst_issue", issue_valid, 3'b000);
    chk("rst_dready", disp_ready, 3'b111);

    // 1: basic dispatch / issue / done
    tick(); disp(0, 0, 0, 0); tick();
    settle();
    chk("t1_issue", issue_valid, 3'b001);
    chk("t1_busy", busy, 3'b001);
    tick(); settle();
    chk("t1_exec_noissue", issue_valid, 3'b000);
    fu_done = 3'b001; tick(); settle();
    chk("t1_done", busy, 3'b000);

    // 2: wakeup by broadcast, then same-cycle wakeup
    disp(1, 7, 0, 0); tick(); settle();
    chk("t2_wait", issue_valid, 3'b000);
    tick();
    wb_valid = 1; wb_tag = 7; settle();
    chk("t2_wb_cycle", issue_valid, 3'b000);
    tick(); settle();
    chk("t2_wake", issue_valid, 3'b010);
    tick(); fu_done = 3'b010; tick();
    disp(2, 7, 0, 0); wb_valid = 1; wb_tag = 7; tick(); settle();
    chk("t2_same_cycle", issue_valid, 3'b100);
    tick(); fu_done = 3'b100; tick(); settle();
    chk("t2_empty", busy, 3'b000);

    // 3: round-robin with wrap, then masked FU1 (ptr is 0 here)
    fu_ready = 3'b000;
    disp(0, 0, 0, 0); tick();
    disp(1, 0, 0, 0); tick();
    disp(2, 0, 0, 0); tick();
    settle();
    chk("t3_all_ready", busy, 3'b111);
    fu_ready = 3'b111; settle();
    chk("t3_g0", issue_valid, 3'b001);
    tick(); fu_done = 3'b001; settle();
    chk("t3_g1", issue_valid, 3'b010);
    tick(); fu_done = 3'b010; disp(0, 0, 0, 0); settle();
    chk("t3_g2", issue_valid, 3'b100);
    tick(); settle();
    chk("t3_wrap", issue_valid, 3'b001);
    tick(); fu_done = 3'b101; disp(1, 0, 0, 0); tick();
    fu_ready = 3'b101; disp(0, 0, 0, 0); settle();
    chk("t3_masked_none", issue_valid, 3'b000);
    tick(); settle();
    chk("t3_skip_fu1", issue_valid, 3'b001);
    tick(); fu_ready = 3'b111; settle();
    chk("t3_fu1_late", issue_valid, 3'b010);
    fu_done = 3'b001; tick(); fu_done = 3'b010; tick(); settle();
    chk("t3_empty", busy, 3'b000);

    // 4: flush with spec EXEC, spec WAIT, non-spec READY
    fu_ready = 3'b000;
    disp(0, 0, 0, 1); tick();
    fu_ready = 3'b001; disp(2, 9, 0, 1); settle();
    chk("t4_alu_issue", issue_valid, 3'b001);
    tick(); fu_ready = 3'b000;
    disp(1, 0, 0, 0); tick();
    flush = 1; fu_ready = 3'b010; settle();
    chk("t4_ls_issue", issue_valid, 3'b010);
    tick(); fu_ready = 3'b111; settle();
    chk("t4_busy", busy, 3'b011);
    chk("t4_dready", disp_ready, 3'b100);
    disp(0, 0, 0, 0); tick(); settle();
    chk("t4_alu_blocked", busy, 3'b011);
    chk("t4_no_issue", issue_valid, 3'b000);
    fu_done = 3'b011; tick(); settle();
    chk("t4_drained", busy, 3'b000);
    fu_ready = 3'b000; disp(2, 0, 0, 1); tick();
    flush = 1; fu_ready = 3'b111; disp(0, 0, 0, 1); settle();
    chk("t4_spec_grant_kill", issue_valid, 3'b000);
    tick(); settle();
    chk("t4_spec_dropped", busy, 3'b000);

    // 5: resolved protects from later flush; flush wins over resolved
    disp(1, 4, 0, 1); tick();
    resolved = 1; tick();
    flush = 1; tick(); settle();
    chk("t5_survive", busy, 3'b010);
    wb_valid = 1; wb_tag = 4; tick(); settle();
    chk("t5_issue", issue_valid, 3'b010);
    tick(); fu_done = 3'b010; tick();
    disp(1, 4, 0, 1); tick();
    flush = 1; resolved = 1; tick(); settle();
    chk("t5_flush_wins", busy, 3'b000);
    disp(2, 3, 0, 1); resolved = 1; tick();
    flush = 1; tick(); settle();
    chk("t5_disp_resolved", busy, 3'b100);
    wb_valid = 1; wb_tag = 3; tick(); settle();
    chk("t5_br_issue", issue_valid, 3'b100);

    // 6: reset with all slots executing
    tick(); disp(0, 0, 0, 0); tick();
    disp(1, 0, 0, 0); tick(); tick(); settle();
    chk("t6_all_exec", busy, 3'b111);
    chk("t6_exec_noissue", issue_valid, 3'b000);
    RST = 1; tick(); RST = 0; settle();
    chk("t6_rst_busy", busy, 3'b000);
    chk("t6_rst_issue", issue_valid, 3'b000);
    fu_done = 3'b111; tick(); settle();
    chk("t6_stale_done", busy, 3'b000);
    chk("t6_dready", disp_ready, 3'b111);
    disp(0, 0, 0, 0); tick(); settle();
    chk("t6_post_issue", issue_valid, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
